cache_refill_ctrl: RTL

- Miss-handling stage downstream of the cache; consumes the cache's hit/miss result and refills the missing line.
- On a miss, fetches one full line from backing memory byte by byte over a req/ack handshake.
- Each returned byte goes to the cache fill port, then completion is signalled.
- busy stalls the CPU-side access path until the refill finishes or aborts.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/refill_timeout.sv | 44 ++++
 rtl/cache_refill_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill controller.
// Holds the default geometry, the refill FSM state encoding and the
// line-base mask helper. Optional feature macro used by the controller:
// CACHE_REFILL_CRITICAL_FIRST_EN.
package cache_pkg;

  localparam int DEF_LINE_BYTES  = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_OFF_W       = $clog2(DEF_LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Mask that clears the low off_w (line offset) bits of an address of up
  // to 32 bits; callers truncate to their own address width.
  function automatic logic [31:0] base_mask(input int off_w);
    return ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/refill_timeout.sv
// Per-byte wait counter for the refill controller. Counts cycles while
// enabled, clears on request, and flags the enabled cycle that would make
// the count reach TIMEOUT_CYC.
module refill_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged on the waiting cycle whose increment hits the limit,
  // so the FSM can leave on that same edge.
  assign expired_o = en_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: fetches one line byte by byte from backing
// memory over a req/ack handshake and writes each byte into the cache fill
// port, ending with a fill_done pulse (or fill_err on a memory timeout).
// Optional macro CACHE_REFILL_CRITICAL_FIRST_EN: fetch starts at the missed
// byte and wraps, and that byte is forwarded early on crit_valid/crit_data.
// All outputs are registered; the address width is assumed to be <= 32.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int LINE_BYTES  = DEF_LINE_BYTES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done,
  output logic              fill_err,
  output logic              busy,
  output logic              crit_valid,
  output logic [DATA_W-1:0] crit_data
);

  localparam int               OFF_W     = $clog2(LINE_BYTES);
  localparam logic [OFF_W-1:0] LAST_BYTE = OFF_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(base_mask(OFF_W));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [OFF_W-1:0]  start_off_s;
  logic              tmo_clr_s, tmo_en_s, tmo_exp_s, cap_s;

  logic              mem_req_q, fill_we_q, fill_done_q, fill_err_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q, fill_addr_q;
  logic [DATA_W-1:0] fill_data_q;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  assign start_off_s = miss_addr[OFF_W-1:0];
`else
  assign start_off_s = {OFF_W{1'b0}};
`endif

  refill_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_1),
    .rst_i    (rst),
    .clear_i  (tmo_clr_s),
    .en_i     (tmo_en_s),
    .expired_o(tmo_exp_s)
  );

  // Refill FSM next-state, line pointer and timeout control.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    tmo_clr_s = 1'b0;
    tmo_en_s  = 1'b0;
    cap_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          base_d    = miss_addr & BASE_MASK;
          off_d     = start_off_s;
          cnt_d     = {OFF_W{1'b0}};
          tmo_clr_s = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          cap_s   = 1'b1;
          state_d = WRITE;
        end else begin
          tmo_en_s = 1'b1;
          if (tmo_exp_s) begin
            state_d = ERR;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRITE: begin
        off_d     = off_q + {{(OFF_W-1){1'b0}}, 1'b1};
        cnt_d     = cnt_q + {{(OFF_W-1){1'b0}}, 1'b1};
        tmo_clr_s = 1'b1;
        if (cnt_q == LAST_BYTE) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and line pointer registers.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= {ADDR_W{1'b0}};
      off_q   <= {OFF_W{1'b0}};
      cnt_q   <= {OFF_W{1'b0}};
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers decoded from the next state so they align with it.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      fill_we_q   <= 1'b0;
      fill_addr_q <= {ADDR_W{1'b0}};
      fill_data_q <= {DATA_W{1'b0}};
      fill_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_req_q   <= (state_d == FETCH);
      fill_we_q   <= (state_d == WRITE);
      fill_done_q <= (state_d == DONE);
      fill_err_q  <= (state_d == ERR);
      busy_q      <= (state_d != IDLE);
      if (state_d == FETCH) begin
        mem_addr_q <= base_d | ADDR_W'(off_d);
      end
      if (cap_s) begin
        fill_addr_q <= mem_addr_q;
        fill_data_q <= mem_rdata;
      end
    end
  end

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  logic              crit_valid_q;
  logic [DATA_W-1:0] crit_data_q;

  // Forward the first fetched byte (the missed one) alongside its write.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= {DATA_W{1'b0}};
    end else begin
      crit_valid_q <= cap_s && (cnt_q == {OFF_W{1'b0}});
      if (cap_s && (cnt_q == {OFF_W{1'b0}})) begin
        crit_data_q <= mem_rdata;
      end
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
`else
  assign crit_valid = 1'b0;
  assign crit_data  = {DATA_W{1'b0}};
`endif

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign fill_we   = fill_we_q;
  assign fill_addr = fill_addr_q;
  assign fill_data = fill_data_q;
  assign fill_done = fill_done_q;
  assign fill_err  = fill_err_q;
  assign busy      = busy_q;

endmodule
